multiword_add_sequencer: RTL and testbench
==========================================

// Module: multiword_add_sequencer
// PURPOSE
// Sequences one SIZE-bit ripple-carry adder slice over WORDS cycles to add or subtract
// two SIZE*WORDS-bit operands. Each cycle it adds one word, least-significant first,
// and registers the slice carry into the next word. Trades latency for area on wide
// arithmetic. Valid/ready handshake on the operand and result sides.
// PARAMETERS
// SIZE   4  width of the adder slice in bits (>=1)
// WORDS  4  number of slices per operation (>=1); operand width W = SIZE*WORDS
// PORTS
// clk        in   1  rising-edge clock
// rst        in   1  asynchronous, active-high reset
// in_valid   in   1  operands present on a, b, cin, sub
// in_ready   out  1  high only in IDLE; the operation is accepted when in_valid & in_ready
// a          in   W  operand A
// b          in   W  operand B
// cin        in   1  carry-in for add (ignored when sub=1)
// sub        in   1  0: A+B+cin; 1: A+~B+1 (A-B)
// res_valid  out  1  result available (DONE state)
// res_ready  in   1  result consumer ready
// sum        out  W  result, registered
// cout       out  1  carry-out of the top word (for sub: 1 = no borrow)
// ovf        out  1  signed overflow = carry-into-MSB ^ carry-out-of-MSB
// busy       out  1  high in RUN or DONE
// BEHAVIOUR
// - Reset (async): state=IDLE, word index=0, carry=0; sum=0, cout=0, ovf=0, res_valid=0,
//   busy=0, in_ready=1 after reset deasserts. Reset mid-operation abandons the operation.
// - FSM: IDLE -> RUN on accept; RUN -> DONE after word WORDS-1; DONE -> IDLE when
//   res_valid & res_ready.
// - Accept edge: latch a, b (b inverted if sub), carry<=sub ? 1 : cin, idx<=0.
// - RUN, per cycle k=idx: {c,s}=a_w[k]+b_w[k]+carry (SIZE+1 bits);
//   sum word k<=s, carry<=c, idx<=idx+1. On k=WORDS-1: cout<=c,
//   ovf<=carry into bit W-1 ^ c, and go to DONE.
// - Latency: res_valid rises exactly WORDS clock edges after the accept edge. With
//   WORDS=1, the accept edge is followed by one RUN cycle, then DONE.
// - sum, cout and ovf are defined only while res_valid=1. They hold stable in DONE
//   until the result is taken. sum may change word-by-word during RUN.
// - Result backpressure: DONE persists indefinitely while res_ready=0.
// - in_ready=0 in RUN/DONE; in_valid there is ignored and has no side effects.
//   No same-cycle accept on the DONE->IDLE edge; the earliest next accept is the
//   following cycle.
// - Inputs a, b, cin, sub may change freely after the accept edge.
// - Throughput: one operation per WORDS+2 cycles at best.
// TESTING (SIZE=4, WORDS=4, W=16)
// 1 add a=0x1234 b=0x0FCD cin=0 -> sum=0x2201 cout=0 ovf=0; res_valid 4 edges after accept
// 2 add a=0xFFFF b=0x0001 cin=0 -> sum=0x0000 cout=1 (carry ripples across all 4 words)
// 3 sub a=0x0005 b=0x0007 -> sum=0xFFFE cout=0; sub a=0x0007 b=0x0005 -> sum=0x0002 cout=1
// 4 add a=0x7FFF b=0x0001 -> sum=0x8000 ovf=1; hold res_ready=0 for 3 cycles -> res_valid,
//   sum, cout and ovf stable; in_ready=0 throughout; in_valid pulses ignored
// 5 assert rst during RUN (idx=2) -> next sample: res_valid=0, sum=0, busy=0; after release,
//   a new op 0x0001+0x0001 -> 0x0002 correct
// 6 back-to-back: in_valid held high with res_ready=1 -> two accepts spaced exactly 6 cycles

Source files
------------

// File: rtl/multiword_add_sequencer.sv
//==============================================================================
// Module      : multiword_add_sequencer
// Description : Adds or subtracts two SIZE*WORDS-bit operands with one SIZE-bit
//               adder slice, one word per cycle, least-significant word first.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module multiword_add_sequencer #(
   parameter int SIZE  = 4,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SIZE*WORDS-1:0] a,
   input  logic [SIZE*WORDS-1:0] b,
   input  logic                  cin,
   input  logic                  sub,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [SIZE*WORDS-1:0] sum,
   output logic                  cout,
   output logic                  ovf,
   output logic                  busy
);

   localparam int W    = SIZE * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] C_LAST = IDXW'(WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic            w_accept;
   logic            w_last;
   logic [SIZE-1:0] w_a_word;
   logic [SIZE-1:0] w_b_word;
   logic [SIZE:0]   w_slice;
   logic            w_c_msb;

   assign w_accept = in_valid && (state_q == S_IDLE);
   assign w_last   = (idx_q == C_LAST);
   assign w_a_word = a_q[idx_q*SIZE +: SIZE];
   assign w_b_word = b_q[idx_q*SIZE +: SIZE];
   assign w_slice  = {1'b0, w_a_word} + {1'b0, w_b_word} + {{SIZE{1'b0}}, carry_q};
   // Carry into the slice MSB recovered from the sum bit; on the last word it is the carry into bit W-1.
   assign w_c_msb  = w_a_word[SIZE-1] ^ w_b_word[SIZE-1] ^ w_slice[SIZE-1];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)  state_d = S_RUN;
         S_RUN:   if (w_last)    state_d = S_DONE;
         S_DONE:  if (res_ready) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      res_valid = (state_q == S_DONE);
      busy      = (state_q == S_RUN) || (state_q == S_DONE);
   end

   // Datapath next-state
   always_comb begin
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (w_accept) begin
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = sub ? 1'b1 : cin;
         idx_d   = '0;
      end else if (state_q == S_RUN) begin
         sum_d[idx_q*SIZE +: SIZE] = w_slice[SIZE-1:0];
         carry_d = w_slice[SIZE];
         idx_d   = idx_q + 1'b1;
         if (w_last) begin
            cout_d = w_slice[SIZE];
            ovf_d  = w_c_msb ^ w_slice[SIZE];
            idx_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
//==============================================================================
// Module      : tb_multiword_add_sequencer
// Description : Directed self-checking bench for multiword_add_sequencer (4x4).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_multiword_add_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;

   int n_cmp;
   int n_fail;

   multiword_add_sequencer #(.SIZE(4), .WORDS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one operation, then scrambles the inputs and counts edges until res_valid.
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin; sub = ~tsub;
      lat = 0;
      while (!res_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_result();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h expected 0000", sum); end
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_cmp++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
   endtask

   task automatic test_add();
      int lat;
      run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, lat);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL add1_latency: got %0d expected 4", lat); end
      n_cmp++; if (sum !== 16'h2201) begin n_fail++; $display("FAIL add1_sum: got %h expected 2201", sum); end
      n_cmp++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL add1_cout_ovf: got %b expected 00", {cout, ovf}); end
      take_result();
      n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL add1_idle: got ready=%b busy=%b expected 1 0", in_ready, busy); end

      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      n_cmp++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL add2_sum: got %h expected 0000", sum); end
      n_cmp++; if ({cout, ovf} !== 2'b10) begin n_fail++; $display("FAIL add2_cout_ovf: got %b expected 10", {cout, ovf}); end
      take_result();

      run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, lat);
      n_cmp++; if (sum !== 16'h0100) begin n_fail++; $display("FAIL add_cin_sum: got %h expected 0100", sum); end
      n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL add_cin_cout: got %b expected 0", cout); end
      take_result();
   endtask

   task automatic test_sub();
      int lat;
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
      n_cmp++; if (sum !== 16'hFFFE) begin n_fail++; $display("FAIL sub1_sum: got %h expected fffe", sum); end
      n_cmp++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL sub1_cout_ovf: got %b expected 00", {cout, ovf}); end
      take_result();
      // cin must be ignored when subtracting
      run_op(16'h0007, 16'h0005, 1'b1, 1'b1, lat);
      n_cmp++; if (sum !== 16'h0002) begin n_fail++; $display("FAIL sub2_sum: got %h expected 0002", sum); end
      n_cmp++; if ({cout, ovf} !== 2'b10) begin n_fail++; $display("FAIL sub2_cout_ovf: got %b expected 10", {cout, ovf}); end
      take_result();
   endtask

   task automatic test_backpressure();
      int lat;
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
      n_cmp++; if (sum !== 16'h8000) begin n_fail++; $display("FAIL ovf_sum: got %h expected 8000", sum); end
      n_cmp++; if ({cout, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_cout_ovf: got %b expected 01", {cout, ovf}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = (i != 1); a = 16'h1111; b = 16'h2222;
         @(posedge clk);
         #1;
         n_cmp++;
         if (res_valid !== 1'b1 || sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1 ||
             in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_%0d: got v=%b sum=%h c=%b o=%b rdy=%b busy=%b expected 1 8000 0 1 0 1",
                     i, res_valid, sum, cout, ovf, in_ready, busy);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      take_result();
      n_cmp++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got ready=%b valid=%b expected 1 0", in_ready, res_valid); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      n_cmp++; if (res_valid !== 1'b0 || sum !== 16'h0000 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst: got valid=%b sum=%h busy=%b expected 0 0000 0", res_valid, sum, busy); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", in_ready); end
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
      n_cmp++; if (lat !== 4 || sum !== 16'h0002) begin n_fail++; $display("FAIL midrst_op: got lat=%0d sum=%h expected 4 0002", lat, sum); end
      take_result();
   endtask

   task automatic test_back_to_back();
      int cyc, nacc, first, second, lat, nres;
      cyc = 0; nacc = 0; first = -1; second = -1; nres = 0;
      @(negedge clk);
      a = 16'h0100; b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
      while (nacc < 2 && cyc < 40) begin
         if (in_ready) begin
            if (nacc == 0) first = cyc; else second = cyc;
            nacc++;
         end
         if (res_valid) begin
            nres++;
            n_cmp++; if (sum !== 16'h0111) begin n_fail++; $display("FAIL b2b_sum1: got %h expected 0111", sum); end
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      n_cmp++; if (nacc !== 2 || second - first !== 6) begin n_fail++; $display("FAIL b2b_spacing: got accepts=%0d spacing=%0d expected 2 6", nacc, second - first); end
      n_cmp++; if (nres !== 1) begin n_fail++; $display("FAIL b2b_res_count: got %0d expected 1", nres); end
      lat = 0;
      while (!res_valid && lat < 20) begin @(negedge clk); lat++; end
      n_cmp++; if (res_valid !== 1'b1 || sum !== 16'h0111) begin n_fail++; $display("FAIL b2b_sum2: got valid=%b sum=%h expected 1 0111", res_valid, sum); end
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b expected 1", in_ready); end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
